// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch read port and a data
// load/store port onto one single-ported synchronous memory.
// Ties are broken round-robin. Each access runs IDLE -> ACCESS ->
// (WAIT x READ_LAT, loads only) -> RESP -> IDLE. Every output is registered.
//
// Ports
//   clk, rst_b                     clock, async active-low reset
//   i_req, i_addr                  fetch request / address (held until i_gnt)
//   i_gnt, i_valid, i_rdata        fetch grant pulse, data-valid pulse, word
//   d_req, d_we, d_addr, d_wdata   data request, 1=store, address, store data
//   d_gnt, d_valid, d_rdata        data grant pulse, done/valid pulse, load word
//   mem_read, mem_write            memory strobes (ACCESS cycle only)
//   mem_addr, mem_din, mem_dout    memory address, write data, read data
//   busy                           high whenever the FSM is not in IDLE
module mem_arbiter #(
   parameter int unsigned AW       = 9,
   parameter int unsigned DW       = 16,
   parameter int unsigned READ_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_valid,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_valid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          busy
);

   localparam int unsigned CW = 2;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          port_q, port_d;   // port being served: 1 = data, 0 = fetch
   logic          we_q, we_d;
   logic          last_q, last_d;   // last served port: 1 = data, 0 = fetch

   logic          i_gnt_d, i_valid_d, d_gnt_d, d_valid_d;
   logic          mem_read_d, mem_write_d, busy_d;
   logic [AW-1:0] mem_addr_d;
   logic [DW-1:0] mem_din_d, i_rdata_d, d_rdata_d;
   logic          pick_d, pick_i;

   // State and output registers
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         port_q    <= 1'b0;
         we_q      <= 1'b0;
         last_q    <= 1'b0;
         i_gnt     <= 1'b0;
         i_valid   <= 1'b0;
         i_rdata   <= '0;
         d_gnt     <= 1'b0;
         d_valid   <= 1'b0;
         d_rdata   <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         port_q    <= port_d;
         we_q      <= we_d;
         last_q    <= last_d;
         i_gnt     <= i_gnt_d;
         i_valid   <= i_valid_d;
         i_rdata   <= i_rdata_d;
         d_gnt     <= d_gnt_d;
         d_valid   <= d_valid_d;
         d_rdata   <= d_rdata_d;
         mem_read  <= mem_read_d;
         mem_write <= mem_write_d;
         mem_addr  <= mem_addr_d;
         mem_din   <= mem_din_d;
         busy      <= busy_d;
      end
   end

   // Round-robin pick: data wins a tie unless it was served last
   assign pick_d = d_req && (!i_req || !last_q);
   assign pick_i = i_req && !pick_d;

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      port_d      = port_q;
      we_d        = we_q;
      last_d      = last_q;
      i_gnt_d     = 1'b0;
      i_valid_d   = 1'b0;
      d_gnt_d     = 1'b0;
      d_valid_d   = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr;
      mem_din_d   = mem_din;
      i_rdata_d   = i_rdata;
      d_rdata_d   = d_rdata;

      unique case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d     = ACCESS;
               port_d      = 1'b1;
               we_d        = d_we;
               last_d      = 1'b1;
               d_gnt_d     = 1'b1;
               mem_addr_d  = d_addr;
               mem_write_d = d_we;
               mem_read_d  = !d_we;
               if (d_we) mem_din_d = d_wdata;
            end else if (pick_i) begin
               state_d    = ACCESS;
               port_d     = 1'b0;
               we_d       = 1'b0;
               last_d     = 1'b0;
               i_gnt_d    = 1'b1;
               mem_addr_d = i_addr;
               mem_read_d = 1'b1;
            end
         end
         ACCESS: begin
            if (we_q) begin
               state_d   = RESP;
               d_valid_d = 1'b1;
            end else begin
               state_d = WAIT;
               cnt_d   = CW'(READ_LAT - 1);
            end
         end
         WAIT: begin
            // mem_dout is valid in the last WAIT cycle; capture it on exit
            if (cnt_q == '0) begin
               state_d = RESP;
               if (port_q) begin
                  d_valid_d = 1'b1;
                  d_rdata_d = mem_dout;
               end else begin
                  i_valid_d = 1'b1;
                  i_rdata_d = mem_dout;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a synchronous memory model
// (READ_LAT = 1) and a free-running protocol monitor.
module tb_mem_arbiter;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 16;
   localparam int unsigned READ_LAT = 1;

   logic          clk = 1'b0;
   logic          rst_b;
   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          i_gnt, i_valid, d_gnt, d_valid;
   logic [DW-1:0] i_rdata, d_rdata;
   logic          mem_read, mem_write, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;

   int pass_cnt = 0;
   int total_cnt = 0;

   mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT)) dut (
      .clk(clk), .rst_b(rst_b),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory model: one-cycle synchronous read, write on strobe
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_read) mem_dout <= mem[mem_addr];
      if (mem_write) mem[mem_addr] = mem_din;
   end

   function automatic logic [DW-1:0] base_word(input logic [AW-1:0] a);
      return 16'(a * 7) ^ 16'h5A3C;
   endfunction

   // Expected memory image after the store to 0x1F0
   function automatic logic [DW-1:0] img(input logic [AW-1:0] a);
      if (a == 9'h005) return 16'h1234;
      if (a == 9'h1F0) return 16'hBEEF;
      return base_word(a);
   endfunction

   // Protocol monitor
   logic i_pend = 1'b0, d_pend = 1'b0, prev_busy = 1'b0;
   always @(negedge clk or negedge rst_b) begin
      if (!rst_b) begin
         i_pend = 1'b0; d_pend = 1'b0; prev_busy = 1'b0;
      end else begin
         total_cnt++;
         if (mem_read && mem_write) $display("FAIL strobes: read=%b write=%b, required not both", mem_read, mem_write);
         else pass_cnt++;
         if (i_gnt || d_gnt) begin
            total_cnt++;
            if (prev_busy || (i_gnt && d_gnt)) $display("FAIL gnt_busy: i_gnt=%b d_gnt=%b prev_busy=%b, required single gnt from idle", i_gnt, d_gnt, prev_busy);
            else pass_cnt++;
         end
         if (i_gnt) begin
            total_cnt++;
            if (i_pend) $display("FAIL i_gnt_dup: outstanding fetch=1, required 0");
            else pass_cnt++;
            i_pend = 1'b1;
         end
         if (d_gnt) begin
            total_cnt++;
            if (d_pend) $display("FAIL d_gnt_dup: outstanding data=1, required 0");
            else pass_cnt++;
            d_pend = 1'b1;
         end
         if (i_valid) begin
            total_cnt++;
            if (!i_pend) $display("FAIL i_valid_extra: outstanding fetch=0, required 1");
            else pass_cnt++;
            i_pend = 1'b0;
         end
         if (d_valid) begin
            total_cnt++;
            if (!d_pend) $display("FAIL d_valid_extra: outstanding data=0, required 1");
            else pass_cnt++;
            d_pend = 1'b0;
         end
         prev_busy = busy;
      end
   end

   task automatic test_reset();
      rst_b = 1'b0; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({i_gnt, i_valid, d_gnt, d_valid, mem_read, mem_write, busy} !== 7'b0)
         $display("FAIL reset_ctl: got %b, required 0000000", {i_gnt, i_valid, d_gnt, d_valid, mem_read, mem_write, busy});
      else pass_cnt++;
      total_cnt++;
      if (mem_addr !== '0 || mem_din !== '0 || i_rdata !== '0 || d_rdata !== '0)
         $display("FAIL reset_data: addr=%h din=%h i_rdata=%h d_rdata=%h, required all 0", mem_addr, mem_din, i_rdata, d_rdata);
      else pass_cnt++;
      rst_b = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b, required 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_fetch();
      i_req = 1'b1; i_addr = 9'h005;
      @(negedge clk);                       // T+1
      total_cnt++;
      if ({i_gnt, mem_read, mem_write, busy, d_gnt} !== 5'b11010 || mem_addr !== 9'h005)
         $display("FAIL fetch_access: gnt/rd/wr/busy/dgnt=%b addr=%h, required 11010 addr 005", {i_gnt, mem_read, mem_write, busy, d_gnt}, mem_addr);
      else pass_cnt++;
      i_req = 1'b0;
      @(negedge clk);                       // T+2
      total_cnt++;
      if ({i_gnt, i_valid, mem_read, busy} !== 4'b0001)
         $display("FAIL fetch_wait: gnt/valid/rd/busy=%b, required 0001", {i_gnt, i_valid, mem_read, busy});
      else pass_cnt++;
      @(negedge clk);                       // T+3
      total_cnt++;
      if (i_valid !== 1'b1 || i_rdata !== 16'h1234 || busy !== 1'b1)
         $display("FAIL fetch_resp: valid=%b rdata=%h busy=%b, required 1 1234 1", i_valid, i_rdata, busy);
      else pass_cnt++;
      @(negedge clk);                       // T+4
      total_cnt++;
      if (i_valid !== 1'b0 || busy !== 1'b0 || i_rdata !== 16'h1234)
         $display("FAIL fetch_hold: valid=%b busy=%b rdata=%h, required 0 0 1234", i_valid, busy, i_rdata);
      else pass_cnt++;
   endtask

   task automatic test_store_load();
      d_req = 1'b1; d_we = 1'b1; d_addr = 9'h1F0; d_wdata = 16'hBEEF;
      @(negedge clk);                       // T+1
      total_cnt++;
      if ({d_gnt, mem_write, mem_read} !== 3'b110 || mem_addr !== 9'h1F0 || mem_din !== 16'hBEEF)
         $display("FAIL store_access: gnt/wr/rd=%b addr=%h din=%h, required 110 1F0 BEEF", {d_gnt, mem_write, mem_read}, mem_addr, mem_din);
      else pass_cnt++;
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);                       // T+2
      total_cnt++;
      if (d_valid !== 1'b1 || mem_read !== 1'b0 || d_rdata !== 16'h0000 || mem_din !== 16'hBEEF)
         $display("FAIL store_resp: valid=%b rd=%b d_rdata=%h din=%h, required 1 0 0000 BEEF", d_valid, mem_read, d_rdata, mem_din);
      else pass_cnt++;
      @(negedge clk);                       // T+3, IDLE
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL store_idle: busy=%b, required 0", busy);
      else pass_cnt++;
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h1F0;
      @(negedge clk);
      total_cnt++;
      if (d_gnt !== 1'b1 || mem_read !== 1'b1) $display("FAIL load_access: gnt=%b rd=%b, required 1 1", d_gnt, mem_read);
      else pass_cnt++;
      d_req = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (d_valid !== 1'b1 || d_rdata !== 16'hBEEF || i_rdata !== 16'h1234)
         $display("FAIL load_resp: valid=%b d_rdata=%h i_rdata=%h, required 1 BEEF 1234", d_valid, d_rdata, i_rdata);
      else pass_cnt++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_tie();
      int n = 0;
      int gcyc [4];
      logic gport [4];
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      i_addr = 9'h005; d_addr = 9'h1F0; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int k = 1; k <= 30 && n < 4; k++) begin
         @(negedge clk);
         if (d_gnt) begin gport[n] = 1'b1; gcyc[n] = k; n++; end
         else if (i_gnt) begin gport[n] = 1'b0; gcyc[n] = k; n++; end
         if (d_valid) begin
            total_cnt++;
            if (d_rdata !== 16'hBEEF) $display("FAIL tie_d_data: got %h, required BEEF", d_rdata);
            else pass_cnt++;
         end
         if (i_valid) begin
            total_cnt++;
            if (i_rdata !== 16'h1234) $display("FAIL tie_i_data: got %h, required 1234", i_rdata);
            else pass_cnt++;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      total_cnt++;
      if (n != 4) $display("FAIL tie_count: got %0d grants, required 4", n);
      else pass_cnt++;
      for (int j = 0; j < n; j++) begin
         total_cnt++;
         if (gport[j] !== ((j % 2) == 0) || gcyc[j] != 1 + 4 * j)
            $display("FAIL tie_order[%0d]: port=%b cycle=%0d, required port %0d cycle %0d", j, gport[j], gcyc[j], (j % 2) == 0, 1 + 4 * j);
         else pass_cnt++;
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_withdraw();
      int igc = 0;
      int dvc = 0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h1F0;
      @(negedge clk);
      total_cnt++;
      if (d_gnt !== 1'b1) $display("FAIL wd_gnt: d_gnt=%b, required 1", d_gnt);
      else pass_cnt++;
      d_req = 1'b0; i_req = 1'b1; i_addr = 9'h005;
      @(negedge clk);
      i_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (i_gnt) igc++;
         if (d_valid) dvc++;
         @(negedge clk);
      end
      total_cnt++;
      if (igc != 0 || dvc != 1) $display("FAIL withdraw: i_gnt count=%0d d_valid count=%0d, required 0 and 1", igc, dvc);
      else pass_cnt++;
   endtask

   task automatic test_reset_wait();
      int dvc = 0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h1F0;
      @(negedge clk);                       // T+1
      d_req = 1'b0;
      @(negedge clk);                       // T+2, WAIT
      total_cnt++;
      if (busy !== 1'b1 || d_valid !== 1'b0) $display("FAIL rw_wait: busy=%b valid=%b, required 1 0", busy, d_valid);
      else pass_cnt++;
      rst_b = 1'b0;
      #1;
      total_cnt++;
      if ({i_gnt, i_valid, d_gnt, d_valid, mem_read, mem_write, busy} !== 7'b0 ||
          mem_addr !== '0 || mem_din !== '0 || i_rdata !== '0 || d_rdata !== '0)
         $display("FAIL rw_outputs: ctl=%b addr=%h din=%h i_rdata=%h d_rdata=%h, required all 0",
                  {i_gnt, i_valid, d_gnt, d_valid, mem_read, mem_write, busy}, mem_addr, mem_din, i_rdata, d_rdata);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (d_valid) dvc++;
      end
      total_cnt++;
      if (dvc != 0) $display("FAIL rw_abort: d_valid count=%0d, required 0", dvc);
      else pass_cnt++;
      i_req = 1'b1; i_addr = 9'h005;
      @(negedge clk);
      total_cnt++;
      if (i_gnt !== 1'b1) $display("FAIL rw_next_gnt: i_gnt=%b, required 1", i_gnt);
      else pass_cnt++;
      i_req = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (i_valid !== 1'b1 || i_rdata !== 16'h1234) $display("FAIL rw_next_data: valid=%b rdata=%h, required 1 1234", i_valid, i_rdata);
      else pass_cnt++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_sweep();
      logic got;
      for (int a = 0; a < (1 << AW); a++) begin
         i_addr = AW'(a); i_req = 1'b1; got = 1'b0;
         for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (i_gnt) i_req = 1'b0;
            if (i_valid) got = 1'b1;
         end
         i_req = 1'b0;
         total_cnt++;
         if (!got || i_rdata !== img(AW'(a)))
            $display("FAIL sweep[%h]: valid_seen=%b rdata=%h, required 1 %h", a, got, i_rdata, img(AW'(a)));
         else pass_cnt++;
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int a = 0; a < (1 << AW); a++) mem[a] = base_word(AW'(a));
      mem[5] = 16'h1234;
      mem_dout = '0;
      test_reset();
      test_fetch();
      test_store_load();
      test_tie();
      test_withdraw();
      test_reset_wait();
      test_sweep();
      total_cnt++;
      if (i_pend || d_pend) $display("FAIL final_pending: fetch=%b data=%b, required 0 0", i_pend, d_pend);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
